keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, clk_i cycles per scan tick; legal range 2..2^20.
REQ-002 Parameter: DEBOUNCE_TICKS, default 20, consecutive matching ticks required to accept a press or a release; legal range 1..255.
REQ-003 The block SHALL have port clk_i, input, 1 bit, system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port row_i, input, 4 bits, keypad row sense lines, active-low and asynchronous to clk_i.
REQ-006 The block SHALL have port col_o, output, 4 bits, keypad column drive, one-hot active-low.
REQ-007 The block SHALL have port key_valid_o, output, 1 bit, one-cycle strobe per accepted press; it is suitable for driving a downstream counter enable.
REQ-008 The block SHALL have port key_code_o, output, 4 bits, code of the last accepted key, equal to row_index*4 + col_index.
REQ-009 The block SHALL have port key_held_o, output, 1 bit, high while an accepted key is still held.

Function
REQ-010 row_i SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value, rows_s.
REQ-011 A tick counter SHALL count 0..SCAN_DIV-1 and wrap to 0; tick is high for the single cycle in which the count equals SCAN_DIV-1.
REQ-012 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, PRESSED and RELEASE; all transitions occur only on tick cycles.
REQ-013 On a tick in SCAN, the following SHALL apply:
- no row low: col_o rotates to the next column (1110 -> 1101 -> 1011 -> 0111 -> 1110);
- exactly one row low: latch the row and column indices, set the debounce count to 1, go to DEBOUNCE (or directly to accepted if DEBOUNCE_TICKS = 1), and hold the column;
- two or more rows low: treat as ghosting and rotate as if no row were low.
REQ-014 On a tick in DEBOUNCE, the following SHALL apply:
- rows_s equals the latched single-row pattern: increment the count; when the count reaches DEBOUNCE_TICKS, accept the press;
- any other pattern: clear the count, rotate the column, return to SCAN.
REQ-015 Accepting a press SHALL, in the same clock edge, load key_code_o, assert key_valid_o for exactly one cycle, set key_held_o = 1, and enter PRESSED.
REQ-016 On a tick in PRESSED, if rows_s = 4'b1111 the FSM SHALL enter RELEASE with the count set to 1; otherwise it stays, and the column stays frozen.
REQ-017 On a tick in RELEASE, the following SHALL apply:
- rows_s = 4'b1111: increment the count; at DEBOUNCE_TICKS, clear key_held_o, rotate the column, go to SCAN;
- any row low: return to PRESSED with no new strobe.
REQ-018 Holding a key SHALL produce exactly one key_valid_o pulse; there is no auto-repeat.
REQ-019 key_code_o SHALL hold its value until the next accepted press.
REQ-020 col_o SHALL be registered, and exactly one bit SHALL be low at all times after reset.
REQ-021 Press latency SHALL be bounded as follows: key_valid_o rises at most 2 + SCAN_DIV*(4 + DEBOUNCE_TICKS) cycles after a stable press begins.

Reset
REQ-022 While rst_n = 0, the block SHALL force state = SCAN, col_o = 4'b1110, key_valid_o = 0, key_code_o = 4'h0, key_held_o = 0, and clear the tick, debounce and synchronizer registers.
REQ-023 Reset asserted mid-debounce or while a key is held SHALL discard the press with no strobe.
REQ-024 After reset release, a key still held SHALL be scanned and accepted as a new press.

Verification (SCAN_DIV = 4, DEBOUNCE_TICKS = 3)
REQ-025 The bench SHALL check reset and idle: assert rst_n = 0, then release with row_i = 4'hF -> col_o = 1110 during reset; col_o steps 1101, 1011, 0111, 1110 every 4 cycles; key_valid_o stays 0.
REQ-026 The bench SHALL check a clean press: hold row 2 low while col_o = 1011 (col 2) -> exactly one key_valid_o pulse, key_code_o = 4'hA, key_held_o = 1 until release plus 3 ticks.
REQ-027 The bench SHALL check a bounce: a row low for 1 tick then high -> no strobe, and scanning resumes at the next column.
REQ-028 The bench SHALL check release chatter: while held, release for 2 ticks, re-press, then release fully -> no second strobe; key_held_o clears only after 3 clean released ticks.
REQ-029 The bench SHALL check ghosting: rows 0 and 1 low simultaneously -> no strobe, and the column keeps rotating.
REQ-030 The bench SHALL check reset mid-press: pulse rst_n low during DEBOUNCE -> outputs return to reset values, and the held key is re-accepted once after release of reset.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces a
// single pressed key on scan ticks and reports it once with its row*4+col code.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    output logic       key_held_o
);

    localparam int             TW        = $clog2(SCAN_DIV);
    localparam logic [TW-1:0]  TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [7:0]     DB_LAST   = 8'(DEBOUNCE_TICKS);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    logic [3:0]    row_meta;
    logic [3:0]    rows_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [1:0]    state;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [3:0]    row_pat;
    logic [7:0]    db_cnt;
    logic [7:0]    db_next;
    logic [3:0]    col_rot;
    logic          one_low;
    logic [1:0]    row_enc;

    // Synchronizer idles at all-ones so reset looks like "no key pressed".
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            rows_s   <= 4'hF;
        end else begin
            row_meta <= row_i;
            rows_s   <= row_meta;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick    = (tick_cnt == TICK_LAST);
    assign db_next = db_cnt + 8'd1;
    assign col_rot = {col_o[2:0], col_o[3]};

    // Only a single low row is a usable press; anything else counts as idle/ghost.
    always_comb begin
        one_low = 1'b1;
        row_enc = 2'd0;
        case (rows_s)
            4'b1110: row_enc = 2'd0;
            4'b1101: row_enc = 2'd1;
            4'b1011: row_enc = 2'd2;
            4'b0111: row_enc = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            col_o       <= 4'b1110;
            col_idx     <= 2'd0;
            row_idx     <= 2'd0;
            row_pat     <= 4'hF;
            db_cnt      <= 8'd0;
            key_valid_o <= 1'b0;
            key_code_o  <= 4'h0;
            key_held_o  <= 1'b0;
        end else begin
            key_valid_o <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (one_low) begin
                            row_idx <= row_enc;
                            row_pat <= rows_s;
                            db_cnt  <= 8'd1;
                            if (DB_LAST == 8'd1) begin
                                key_code_o  <= {row_enc, col_idx};
                                key_valid_o <= 1'b1;
                                key_held_o  <= 1'b1;
                                state       <= PRESSED;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end else begin
                            col_o   <= col_rot;
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (rows_s == row_pat) begin
                            db_cnt <= db_next;
                            if (db_next >= DB_LAST) begin
                                key_code_o  <= {row_idx, col_idx};
                                key_valid_o <= 1'b1;
                                key_held_o  <= 1'b1;
                                state       <= PRESSED;
                            end
                        end else begin
                            db_cnt  <= 8'd0;
                            col_o   <= col_rot;
                            col_idx <= col_idx + 2'd1;
                            state   <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (rows_s == 4'hF) begin
                            db_cnt <= 8'd1;
                            if (DB_LAST == 8'd1) begin
                                key_held_o <= 1'b0;
                                col_o      <= col_rot;
                                col_idx    <= col_idx + 2'd1;
                                state      <= SCAN;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (rows_s == 4'hF) begin
                            db_cnt <= db_next;
                            if (db_next >= DB_LAST) begin
                                db_cnt     <= 8'd0;
                                key_held_o <= 1'b0;
                                col_o      <= col_rot;
                                col_idx    <= col_idx + 2'd1;
                                state      <= SCAN;
                            end
                        end else begin
                            state <= PRESSED;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule
